led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CH, default 4: number of independent LED channels, range 1..16.
REQ-002 Parameter CNT_W, default 24: width of per-channel period/duty counters.
REQ-003 Parameter PRESCALE, default 10000: clk cycles per tick, range 1..2^24.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cfg_we  input  1  configuration write strobe, one cycle per write.
REQ-007 cfg_ch  input  4  target channel index.
REQ-008 cfg_mode  input  2  0=OFF, 1=ON, 2=PWM, 3=PULSE.
REQ-009 cfg_period  input  CNT_W  period in ticks.
REQ-010 cfg_duty  input  CNT_W  on-time in ticks per period.
REQ-011 cfg_count  input  8  number of periods for PULSE mode.
REQ-012 led  output  CH  registered LED drive, bit i = channel i.
REQ-013 busy  output  CH  registered; bit i high while channel i is in PULSE RUN.
REQ-014 tick  output  1  registered one-cycle strobe at prescaler wrap.

Function
REQ-015 Prescaler counts 0..PRESCALE-1, wraps to 0; tick SHALL be 1 in the cycle the prescaler holds PRESCALE-1; PRESCALE=1 gives tick every cycle.
REQ-016 Each channel SHALL hold mode, period, duty, remaining-count and phase registers; a write latches cfg_* into channel cfg_ch.
REQ-017 Writes with cfg_ch >= CH SHALL be ignored; no channel state changes.
REQ-018 A write SHALL set that channel's phase to 0 and, for PULSE, remaining-count to cfg_count; the write takes priority over a coincident tick for that channel.
REQ-019 Effective period = max(cfg_period, 1); phase SHALL advance by 1 on each tick and wrap from period-1 to 0.
REQ-020 OFF: led=0, phase frozen. ON: led=1, phase frozen.
REQ-021 PWM: led=1 when phase < duty, else 0; duty=0 gives constant 0; duty >= period gives constant 1.
REQ-022 PULSE channel states: RUN and DONE; write with cfg_count>0 enters RUN, cfg_count=0 enters DONE directly.
REQ-023 PULSE RUN: led as in PWM; on each phase wrap remaining-count decrements; when it decrements from 1 to 0 the channel SHALL enter DONE in the same cycle.
REQ-024 PULSE DONE: led=0, busy=0, phase frozen at 0, until the next write to that channel.
REQ-025 busy[i]=1 exactly while channel i is in PULSE RUN.
REQ-026 led SHALL be computed from next-state phase/mode and registered: after a write at edge k, led at edge k equals the phase-0 value of the new configuration (1-cycle write-to-led latency).
REQ-027 Channels SHALL be fully independent; a write to one channel SHALL not perturb phase or output of any other.
REQ-028 Phase and count arithmetic SHALL be unsigned CNT_W/8-bit with no overflow beyond the defined wrap.

Reset
REQ-029 While rst=0 at a clock edge: prescaler=0, tick=0, all channels mode=OFF, phase=0, period=1, duty=0, count=0, led=0, busy=0.
REQ-030 Reset SHALL override any coincident cfg_we; reset mid-PULSE aborts to OFF with busy=0 the following cycle.
REQ-031 After rst returns to 1, first tick SHALL occur PRESCALE cycles after the first non-reset edge.

Verification
REQ-032 PRESCALE=4, rst released -> tick high every 4th cycle, first 4 cycles after release; led=0, busy=0 throughout.
REQ-033 PRESCALE=4, write ch0 PWM period=4 duty=1 -> led[0] 1 for 4 cycles then 0 for 12, repeating; other led bits stay 0.
REQ-034 Write ch2 PULSE period=2 duty=1 count=3 -> busy[2] high for exactly 6 ticks, led[2] shows 3 pulses, then DONE: led[2]=0, busy[2]=0.
REQ-035 PWM duty=0 and duty=period=5 on ch1 -> led[1] constant 0, then constant 1; write cfg_ch=7 with CH=4 -> no output change on any channel.
REQ-036 Write to ch3 coincident with tick while ch3 in PWM phase 3 -> phase 0 next cycle, led[3] reflects phase 0 one cycle after write.
REQ-037 Assert rst during ch2 PULSE RUN -> next cycle led=0, busy=0, tick=0; no residual pulses after release.

Source files
------------

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED pattern generator. A shared prescaler produces a tick
// every PRESCALE clock cycles. Each channel has its own period/duty/phase
// registers and runs in one of four modes: OFF, ON, PWM, or PULSE (a burst
// of cfg_count PWM periods that then stops and holds the LED dark).
//
// Parameters
//   CH         number of LED channels (1..16)
//   CNT_W      width of the period/duty/phase counters
//   PRESCALE   clk cycles per tick (1..2^24)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-low reset
//   cfg_we      one-cycle configuration write strobe
//   cfg_ch      channel index targeted by the write (ignored if >= CH)
//   cfg_mode    0=OFF 1=ON 2=PWM 3=PULSE
//   cfg_period  period in ticks (0 is treated as 1)
//   cfg_duty    on-time in ticks per period
//   cfg_count   number of periods to emit in PULSE mode
//   led         registered LED drive, bit i = channel i
//   busy        registered, bit i high while channel i is emitting a PULSE burst
//   tick        registered one-cycle strobe while the prescaler holds its top value
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int CH       = 4,
  parameter int CNT_W    = 24,
  parameter int PRESCALE = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [7:0]       cfg_count,
  output logic [CH-1:0]    led,
  output logic [CH-1:0]    busy,
  output logic             tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  localparam int                PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

  // Prescaler
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;

  // Per-channel state. run_q is the PULSE sub-state: 1 = RUN, 0 = DONE.
  mode_e            mode_q   [CH];
  mode_e            mode_d   [CH];
  logic [CNT_W-1:0] period_q [CH];
  logic [CNT_W-1:0] period_d [CH];
  logic [CNT_W-1:0] duty_q   [CH];
  logic [CNT_W-1:0] duty_d   [CH];
  logic [CNT_W-1:0] phase_q  [CH];
  logic [CNT_W-1:0] phase_d  [CH];
  logic [7:0]       rem_q    [CH];
  logic [7:0]       rem_d    [CH];
  logic [CH-1:0]    run_q, run_d;

  // Registered outputs
  logic [CH-1:0] led_q, led_d;
  logic [CH-1:0] busy_q, busy_d;

  assign led  = led_q;
  assign busy = busy_q;
  assign tick = tick_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked logic uses <= only, so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
      busy_q <= '0;
      run_q  <= '0;
      // NOTE: channel registers are plain flops rather than a RAM, so they are
      // reset explicitly; a reset mid-burst must leave no stale phase or count.
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= ONE;
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
        rem_q[i]    <= '0;
      end
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      busy_q <= busy_d;
      run_q  <= run_d;
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        phase_q[i]  <= phase_d[i];
        rem_q[i]    <= rem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state value gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    ps_d   = (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
    // tick is registered, so it is derived from the value the prescaler is
    // about to hold; that keeps tick aligned with the top count.
    tick_d = (ps_d == PS_MAX);
    run_d  = run_q;

    for (int i = 0; i < CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      phase_d[i]  = phase_q[i];
      rem_d[i]    = rem_q[i];

      // Matching against i (always < CH) also discards out-of-range indices.
      if (cfg_we && (cfg_ch == 4'(i))) begin
        // A write restarts the channel and wins over a coincident tick.
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = (cfg_period == '0) ? ONE : cfg_period;
        duty_d[i]   = cfg_duty;
        phase_d[i]  = '0;
        if (mode_e'(cfg_mode) == MODE_PULSE) begin
          rem_d[i] = cfg_count;
          run_d[i] = (cfg_count != 8'd0);
        end else begin
          run_d[i] = 1'b0;
        end
      end else if (tick_q && ((mode_q[i] == MODE_PWM) ||
                              ((mode_q[i] == MODE_PULSE) && run_q[i]))) begin
        if (phase_q[i] >= period_q[i] - ONE) begin
          phase_d[i] = '0;
          if (mode_q[i] == MODE_PULSE) begin
            rem_d[i] = rem_q[i] - 8'd1;
            // Last period just finished: drop into DONE on this same edge.
            if (rem_q[i] == 8'd1) begin
              run_d[i] = 1'b0;
            end
          end
        end else begin
          phase_d[i] = phase_q[i] + ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from next state so a write shows on led one edge
  // later, at the phase-0 value of the new configuration.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d  = '0;
    busy_d = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode_d[i])
        MODE_ON:    led_d[i] = 1'b1;
        MODE_PWM:   led_d[i] = (phase_d[i] < duty_d[i]);
        MODE_PULSE: led_d[i] = run_d[i] && (phase_d[i] < duty_d[i]);
        default:    led_d[i] = 1'b0;
      endcase
      busy_d[i] = (mode_d[i] == MODE_PULSE) && run_d[i];
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Directed bench for led_pattern_gen with CH=4, PRESCALE=4. Inputs change 1ns
// after each rising edge and outputs are checked at that same point, so every
// check sees the values registered by edge number e (edges counted from the
// first edge after reset release). Expected values come from hand-derived
// per-channel waveforms keyed on the edge at which each channel was written.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int CH    = 4;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic [7:0]       cfg_count;
  logic [CH-1:0]    led;
  logic [CH-1:0]    busy;
  logic             tick;

  led_pattern_gen #(
    .CH       (CH),
    .CNT_W    (CNT_W),
    .PRESCALE (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_count  (cfg_count),
    .led        (led),
    .busy       (busy),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e;          // edges since reset release

  // Waveform anchors: edge of the write that started each channel, -1 = idle.
  int   t0;       // ch0 PWM period 4 duty 1
  logic ch1_val;  // ch1 constant level
  int   k2;       // ch2 PULSE period 2 duty 1 count 3
  int   k3;       // ch3 PWM p8 d4, then rewritten at k3+16 to p8 d1
  logic in_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_led();
    logic [3:0] v;
    int d;
    v = 4'b0000;
    if (!in_reset) begin
      if (t0 >= 0 && e >= t0) v[0] = ((e - t0) % 16) < 4;
      v[1] = ch1_val;
      if (k2 >= 0 && e >= k2) begin
        d = e - k2;
        v[2] = (d < 24) && ((d % 8) < 4);
      end
      if (k3 >= 0 && e >= k3) begin
        d = e - k3;
        v[3] = (d < 16) ? 1'b1 : (((d - 16) % 32) < 4);
      end
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] v;
    v = 4'b0000;
    if (!in_reset && k2 >= 0 && e >= k2 && (e - k2) < 24) v[2] = 1'b1;
    return v;
  endfunction

  // Advance one edge, drop any write strobe, and check all outputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    e++;
    check("led",  32'(led),  32'(exp_led()));
    check("busy", 32'(busy), 32'(exp_busy()));
    check("tick", 32'(tick), 32'((!in_reset) && (e % 4 == 3)));
  endtask

  // Present a write; it is captured by the next cyc().
  task automatic wr(input logic [3:0] ch, input logic [1:0] mode,
                    input int period, input int duty, input int count);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = CNT_W'(period);
    cfg_duty   = CNT_W'(duty);
    cfg_count  = 8'(count);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0; cfg_count = '0;
    e = 0; t0 = -1; ch1_val = 1'b0; k2 = -1; k3 = -1; in_reset = 1'b1;

    // Reset state, with a write to ch0 ON that reset must override.
    repeat (2) cyc();
    wr(4'd0, 2'd1, 1, 0, 0);
    cyc();
    cyc();

    // Release: tick on edges 3,7,11,..., all LEDs dark.
    rst = 1'b1; in_reset = 1'b0; e = 0;
    repeat (15) cyc();

    // ch0 PWM p4 d1 written on a tick edge: 4 cycles on, 12 off.
    wr(4'd0, 2'd2, 4, 1, 0); t0 = e + 1;
    repeat (32) cyc();

    // ch2 PULSE p2 d1 count 3: three pulses, busy for 6 ticks, then DONE.
    wr(4'd2, 2'd3, 2, 1, 3); k2 = e + 1;
    repeat (32) cyc();

    // ch1 PWM duty=0 -> constant 0, then duty=period=5 -> constant 1.
    wr(4'd1, 2'd2, 5, 0, 0); ch1_val = 1'b0;
    repeat (20) cyc();
    wr(4'd1, 2'd2, 5, 5, 0); ch1_val = 1'b1;
    repeat (20) cyc();

    // Out-of-range channel 7 set to ON: nothing may change.
    wr(4'd7, 2'd1, 1, 0, 0);
    repeat (12) cyc();

    // ch3 PWM p8 d4; rewrite to p8 d1 exactly when phase 3 meets a tick.
    wr(4'd3, 2'd2, 8, 4, 0); k3 = e + 1;
    repeat (16) cyc();
    wr(4'd3, 2'd2, 8, 1, 0);
    repeat (36) cyc();

    // Reset in the middle of a ch2 PULSE burst.
    wr(4'd2, 2'd3, 2, 1, 3); k2 = e + 1;
    repeat (10) cyc();
    check("busy2_before_rst", 32'(busy[2]), 32'd1);
    rst = 1'b0; in_reset = 1'b1;
    repeat (2) cyc();
    rst = 1'b1; in_reset = 1'b0; e = 0;
    t0 = -1; ch1_val = 1'b0; k2 = -1; k3 = -1;
    repeat (20) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
